// File: rtl/kbd_tx_ctrl.sv
// kbd_tx_ctrl: FIFO-buffered Amiga keyboard frame sequencer with CIA handshake, timeout resync and grant arbitration.
// Optional KBD_POWERUP_SEQ_EN sends 0xFD/0xFE init frames after reset before any queued keycode.
module kbd_tx_ctrl #(
   parameter int TICK_DIV      = 14,
   parameter int T_PHASE_US    = 20,
   parameter int HS_TIMEOUT_US = 143000,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                          CLKCPU_A,
   input  logic                          RESET_N,
   input  logic [7:0]                    KEY_CODE,
   input  logic                          KEY_VALID,
   output logic                          KEY_READY,
   input  logic                          KB_GRANT,
   input  logic                          KB_DATA_IN,
   output logic                          KB_CLOCK_LO,
   output logic                          KB_DATA_LO,
   output logic                          BUSY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          OVERFLOW,
   input  logic                          OVF_CLR
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int TW = $clog2(T_PHASE_US + 1);
   localparam int HW = $clog2(HS_TIMEOUT_US + 1);

   typedef enum logic [2:0] {IDLE, SETUP, CLK_LO, CLK_HI, RELEASE, HS_LOW, HS_HIGH, RESYNC} state_t;

   logic [PW-1:0] pre;
   logic          tick;
   logic [1:0]    sync;
   logic          kdat;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [LW-1:0] lvl, lvl_nx;
   logic          rdy, ovf, push, drop, pop_req, pop_fifo, avail;
   logic [7:0]    head;
   state_t        st;
   logic [2:0]    bcnt;
   logic [1:0]    ph;
   logic [7:0]    tx;
   logic [TW-1:0] pt;
   logic [HW-1:0] ht;
   logic          low_seen, retried, clk_lo, dat_lo, busy;
   logic          drive, phase_end, hs_to;

   assign tick = pre == PW'(TICK_DIV - 1);
   assign kdat = sync[1];

   always_ff @(posedge CLKCPU_A or negedge RESET_N)
      if (!RESET_N) begin
         pre  <= '0;
         sync <= 2'b11;
      end else begin
         pre  <= tick ? '0 : pre + 1'b1;
         sync <= {sync[0], KB_DATA_IN};
      end

   assign push   = KEY_VALID & rdy;
   assign drop   = KEY_VALID & (lvl == LW'(FIFO_DEPTH));
   assign lvl_nx = lvl + LW'(push) - LW'(pop_fifo);

   always_ff @(posedge CLKCPU_A)
      if (push) mem[wp] <= KEY_CODE;

   always_ff @(posedge CLKCPU_A or negedge RESET_N)
      if (!RESET_N) begin
         wp  <= '0;
         rp  <= '0;
         lvl <= '0;
         rdy <= 1'b0;
         ovf <= 1'b0;
      end else begin
         wp  <= wp + AW'(push);
         rp  <= rp + AW'(pop_fifo);
         lvl <= lvl_nx;
         rdy <= lvl_nx != LW'(FIFO_DEPTH);
         ovf <= drop | (ovf & ~OVF_CLR);
      end

   // A handshake completed after a resync leaves the byte queued so it is resent.
   assign pop_req = (st == HS_HIGH) & kdat & ~retried;

`ifdef KBD_POWERUP_SEQ_EN
   logic [1:0] pu;
   logic       pu_act;
   assign pu_act   = pu != 2'd2;
   assign head     = pu_act ? (pu[0] ? 8'hFE : 8'hFD) : mem[rp];
   assign avail    = pu_act | (lvl != '0);
   assign pop_fifo = pop_req & ~pu_act;
   always_ff @(posedge CLKCPU_A or negedge RESET_N)
      if (!RESET_N) pu <= 2'd0;
      else if (pop_req & pu_act) pu <= pu + 2'd1;
`else
   assign head     = mem[rp];
   assign avail    = lvl != '0;
   assign pop_fifo = pop_req;
`endif

   assign drive     = st inside {SETUP, CLK_LO, CLK_HI, RESYNC};
   assign phase_end = tick && pt == TW'(T_PHASE_US - 1);
   assign hs_to     = tick && ht == HW'(HS_TIMEOUT_US - 1);

   always_ff @(posedge CLKCPU_A or negedge RESET_N)
      if (!RESET_N) begin
         pt <= '0;
         ht <= '0;
      end else begin
         pt <= (!drive || phase_end) ? '0 : pt + TW'(tick && pt != TW'(T_PHASE_US));
         ht <= (st inside {HS_LOW, HS_HIGH}) ? ht + HW'(tick && ht != HW'(HS_TIMEOUT_US)) : '0;
      end

   always_ff @(posedge CLKCPU_A or negedge RESET_N)
      if (!RESET_N) begin
         st       <= IDLE;
         bcnt     <= 3'd0;
         ph       <= 2'd0;
         tx       <= 8'd0;
         low_seen <= 1'b0;
         retried  <= 1'b0;
         clk_lo   <= 1'b0;
         dat_lo   <= 1'b0;
         busy     <= 1'b0;
      end else if (drive && !KB_GRANT) begin
         st     <= IDLE;
         clk_lo <= 1'b0;
         dat_lo <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (st)
            IDLE:
               if (avail && KB_GRANT) begin
                  st      <= SETUP;
                  tx      <= {head[6:0], head[7]};
                  bcnt    <= 3'd7;
                  dat_lo  <= head[6];
                  busy    <= 1'b1;
                  retried <= 1'b0;
               end
            SETUP:
               if (phase_end) begin
                  st     <= CLK_LO;
                  clk_lo <= 1'b1;
               end
            CLK_LO:
               if (phase_end) begin
                  st     <= CLK_HI;
                  clk_lo <= 1'b0;
               end
            CLK_HI:
               if (phase_end) begin
                  bcnt   <= bcnt - 3'd1;
                  st     <= (bcnt == 3'd0) ? RELEASE : SETUP;
                  dat_lo <= (bcnt != 3'd0) & tx[bcnt - 3'd1];
               end
            RELEASE:
               if (tick) begin
                  st       <= HS_LOW;
                  low_seen <= 1'b0;
               end
            HS_LOW:
               if (hs_to) begin
                  st      <= RESYNC;
                  ph      <= 2'd0;
                  dat_lo  <= 1'b1;
                  retried <= 1'b1;
               end else if (tick) begin
                  low_seen <= !kdat;
                  if (!kdat && low_seen) st <= HS_HIGH;
               end
            HS_HIGH:
               if (kdat) begin
                  st   <= IDLE;
                  busy <= 1'b0;
               end else if (hs_to) begin
                  st      <= RESYNC;
                  ph      <= 2'd0;
                  dat_lo  <= 1'b1;
                  retried <= 1'b1;
               end
            RESYNC:
               if (phase_end) begin
                  ph     <= ph + 2'd1;
                  clk_lo <= ph == 2'd0;
                  if (ph == 2'd2) begin
                     st       <= HS_LOW;
                     dat_lo   <= 1'b0;
                     low_seen <= 1'b0;
                  end
               end
            default: st <= IDLE;
         endcase
      end

   assign KEY_READY   = rdy;
   assign KB_CLOCK_LO = clk_lo;
   assign KB_DATA_LO  = dat_lo;
   assign BUSY        = busy;
   assign FIFO_LEVEL  = lvl;
   assign OVERFLOW    = ovf;
endmodule
